// File: rtl/tdm_demux_1_8.sv
// Serial 1:8 TDM demultiplexer: locks to a channel-0 frame marker, gathers
// eight channel bits per frame and presents each complete frame in parallel.
module tdm_demux_1_8 #(
  parameter int MISS_LIMIT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       din_valid,
  input  logic       fsync,
  output logic [7:0] dout,
  output logic       dout_valid,
  output logic [2:0] slot,
  output logic       locked,
  output logic       sync_err
);

  localparam logic [2:0] LIMIT = 3'(MISS_LIMIT);

  typedef enum logic {
    HUNT,
    LOCKED
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [2:0] slot_nx;
  logic [2:0] miss;
  logic [2:0] miss_nx;
  logic [2:0] miss_inc;
  logic [7:0] staging;
  logic [7:0] staging_nx;
  logic [7:0] dout_nx;
  logic       dout_valid_nx;
  logic       sync_err_nx;

  assign miss_inc = miss + 3'd1;

  // Every channel-0 acceptance restarts staging so a discarded partial frame
  // cannot leak stale bits into the next one.
  always_comb begin
    state_nx      = state;
    slot_nx       = slot;
    staging_nx    = staging;
    miss_nx       = miss;
    dout_nx       = dout;
    dout_valid_nx = 1'b0;
    sync_err_nx   = 1'b0;
    if (din_valid) begin
      if (state == HUNT) begin
        if (fsync) begin
          staging_nx = {7'b0, din};
          slot_nx    = 3'd1;
          miss_nx    = 3'd0;
          state_nx   = LOCKED;
        end
      end else if (fsync) begin
        sync_err_nx = (slot != 3'd0);
        staging_nx  = {7'b0, din};
        slot_nx     = 3'd1;
        miss_nx     = 3'd0;
      end else if (slot == 3'd0) begin
        sync_err_nx = 1'b1;
        if (miss_inc >= LIMIT) begin
          staging_nx = 8'h00;
          slot_nx    = 3'd0;
          miss_nx    = 3'd0;
          state_nx   = HUNT;
        end else begin
          staging_nx = {7'b0, din};
          slot_nx    = 3'd1;
          miss_nx    = miss_inc;
        end
      end else begin
        staging_nx[slot] = din;
        slot_nx          = slot + 3'd1;
        if (slot == 3'd7) begin
          dout_nx       = {din, staging[6:0]};
          dout_valid_nx = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= HUNT;
      slot       <= 3'd0;
      staging    <= 8'h00;
      miss       <= 3'd0;
      dout       <= 8'h00;
      dout_valid <= 1'b0;
      locked     <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      state      <= state_nx;
      slot       <= slot_nx;
      staging    <= staging_nx;
      miss       <= miss_nx;
      dout       <= dout_nx;
      dout_valid <= dout_valid_nx;
      locked     <= (state_nx == LOCKED);
      sync_err   <= sync_err_nx;
    end
  end

endmodule

// File: tb/tb_tdm_demux_1_8.sv
// Bench for tdm_demux_1_8: a queue-based frame model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_tdm_demux_1_8;

  localparam int LIMIT = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       din;
  logic       din_valid;
  logic       fsync;
  logic [7:0] dout;
  logic       dout_valid;
  logic [2:0] slot;
  logic       locked;
  logic       sync_err;

  int tests = 0;
  int fails = 0;
  int dv_seen = 0;
  int err_seen = 0;
  bit checking = 1'b0;

  bit         m_locked = 1'b0;
  bit         q[$];
  int         m_miss = 0;
  logic [7:0] m_dout = 8'h00;
  bit         m_dv = 1'b0;
  bit         m_err = 1'b0;

  always #5 clk = ~clk;

  tdm_demux_1_8 #(.MISS_LIMIT(LIMIT)) dut (
    .clk(clk),
    .rst(rst),
    .din(din),
    .din_valid(din_valid),
    .fsync(fsync),
    .dout(dout),
    .dout_valid(dout_valid),
    .slot(slot),
    .locked(locked),
    .sync_err(sync_err)
  );

  // Model: the queue holds the bits of the frame being collected, so its
  // length is the slot the next beat lands in.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_locked = 1'b0;
      q.delete();
      m_miss = 0;
      m_dout = 8'h00;
      m_dv   = 1'b0;
      m_err  = 1'b0;
    end else begin
      m_dv  = 1'b0;
      m_err = 1'b0;
      if (din_valid) begin
        if (fsync) begin
          if (m_locked && q.size() != 0) m_err = 1'b1;
          m_locked = 1'b1;
          q.delete();
          q.push_back(din);
          m_miss = 0;
        end else if (m_locked) begin
          if (q.size() == 0) begin
            m_err = 1'b1;
            m_miss++;
            if (m_miss >= LIMIT) begin
              m_locked = 1'b0;
              m_miss   = 0;
            end else begin
              q.push_back(din);
            end
          end else begin
            q.push_back(din);
            if (q.size() == 8) begin
              for (int k = 0; k < 8; k++) m_dout[k] = q[k];
              m_dv = 1'b1;
              q.delete();
            end
          end
        end
      end
    end
  end

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      if (dout_valid === 1'b1) dv_seen++;
      if (sync_err === 1'b1) err_seen++;
      check_output("dout", dout, m_dout);
      check_output("dout_valid", {7'b0, dout_valid}, {7'b0, m_dv});
      check_output("slot", {5'b0, slot}, 8'(q.size()));
      check_output("locked", {7'b0, locked}, {7'b0, m_locked});
      check_output("sync_err", {7'b0, sync_err}, {7'b0, m_err});
    end
  end

  // Inputs change 1 time unit after the rising edge, so every edge samples
  // the values set by the previous call.
  task automatic apply_stimulus(input logic d, input logic f, input logic v);
    @(posedge clk);
    #1;
    din       = d;
    fsync     = f;
    din_valid = v;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic fs0, input int gap);
    for (int k = 0; k < 8; k++) begin
      apply_stimulus(data[k], (k == 0) ? fs0 : 1'b0, 1'b1);
      if (gap > 0 && (k == 2 || k == 5))
        for (int g = 0; g < gap; g++) apply_stimulus(1'b1, 1'b1, 1'b0);
    end
  endtask

  initial begin
    rst       = 1'b1;
    din       = 1'b0;
    fsync     = 1'b0;
    din_valid = 1'b0;
    @(posedge clk);
    #1;
    checking = 1'b1;
    repeat (2) apply_stimulus(1'b0, 1'b0, 1'b0);
    check_output("reset dout", dout, 8'h00);
    check_output("reset slot", {5'b0, slot}, 8'h00);
    check_output("reset locked", {7'b0, locked}, 8'h00);
    check_output("reset dout_valid", {7'b0, dout_valid}, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // HUNT ignores beats without a frame marker
    for (int i = 0; i < 20; i++) apply_stimulus(i[0], 1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    check_output("hunt locked", {7'b0, locked}, 8'h00);
    check_output("hunt slot", {5'b0, slot}, 8'h00);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    check_output("hunt dv count", 8'(dv_seen), 8'd0);

    send_frame(8'h4D, 1'b1, 0);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    check_output("aligned dout", dout, 8'h4D);
    check_output("aligned dout_valid", {7'b0, dout_valid}, 8'h01);
    check_output("aligned locked", {7'b0, locked}, 8'h01);
    apply_stimulus(1'b0, 1'b0, 1'b0);

    send_frame(8'h4D, 1'b1, 3);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    check_output("gapped dout", dout, 8'h4D);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    check_output("gapped dv count", 8'(dv_seen), 8'd2);
    check_output("clean err count", 8'(err_seen), 8'd0);

    // Early marker at slot 4 restarts the frame
    send_frame(8'hA5, 1'b1, 0);
    apply_stimulus(1'b1, 1'b1, 1'b1);
    repeat (3) apply_stimulus(1'b1, 1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b1, 1'b1);
    apply_stimulus(1'b0, 1'b0, 1'b1);
    check_output("early sync_err", {7'b0, sync_err}, 8'h01);
    check_output("early slot", {5'b0, slot}, 8'h01);
    check_output("early dout kept", dout, 8'hA5);
    apply_stimulus(1'b1, 1'b0, 1'b1);
    apply_stimulus(1'b1, 1'b0, 1'b1);
    apply_stimulus(1'b1, 1'b0, 1'b1);
    apply_stimulus(1'b1, 1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    check_output("early dout", dout, 8'h3C);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    check_output("early dv count", 8'(dv_seen), 8'd4);

    // Two consecutive missing markers drop lock
    send_frame(8'h81, 1'b0, 0);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    check_output("miss1 dout", dout, 8'h81);
    check_output("miss1 locked", {7'b0, locked}, 8'h01);
    apply_stimulus(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    check_output("miss2 locked", {7'b0, locked}, 8'h00);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    check_output("miss dv count", 8'(dv_seen), 8'd5);
    check_output("miss err count", 8'(err_seen), 8'd3);

    // Reset mid-frame, then relock
    send_frame(8'h5A, 1'b1, 0);
    apply_stimulus(1'b1, 1'b1, 1'b1);
    repeat (4) apply_stimulus(1'b1, 1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    check_output("pre-reset slot", {5'b0, slot}, 8'h05);
    rst = 1'b1;
    #1;
    check_output("midreset dout", dout, 8'h00);
    check_output("midreset slot", {5'b0, slot}, 8'h00);
    check_output("midreset locked", {7'b0, locked}, 8'h00);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (3) apply_stimulus(1'b1, 1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    check_output("post-reset locked", {7'b0, locked}, 8'h00);
    send_frame(8'hC3, 1'b1, 0);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    check_output("relock dout", dout, 8'hC3);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    check_output("final dv count", 8'(dv_seen), 8'd7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tdm_demux_1_8.md
TDM_DEMUX_1_8 -- requirements
Module: tdm_demux_1_8

Interface
REQ-001 SHALL have parameter: MISS_LIMIT, default 2, consecutive missing frame syncs tolerated before lock loss (legal range 1..7).
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: din  input  1  serial TDM data bit, one channel per beat, channel 0 first.
REQ-005 SHALL have port: din_valid  input  1  beat qualifier; din/fsync sampled only when high.
REQ-006 SHALL have port: fsync  input  1  frame marker, high on the channel-0 beat.
REQ-007 SHALL have port: dout  output  8  last complete frame; dout[k] = channel k bit.
REQ-008 SHALL have port: dout_valid  output  1  one-cycle pulse, dout updated this cycle.
REQ-009 SHALL have port: slot  output  3  channel index the next accepted beat will be written to.
REQ-010 SHALL have port: locked  output  1  high in LOCKED state.
REQ-011 SHALL have port: sync_err  output  1  one-cycle pulse on any frame-alignment error.

Function
REQ-012 SHALL implement two states, HUNT and LOCKED; a beat = rising edge with din_valid=1.
REQ-013 SHALL, in HUNT, ignore beats with fsync=0; on a beat with fsync=1 store din to staging[0], set slot=1, clear miss count, enter LOCKED.
REQ-014 SHALL, in LOCKED, write din to staging[slot] on each beat and advance slot modulo 8 (7 -> 0).
REQ-015 SHALL, on the slot-7 beat, load dout with {din, staging[6:0]} and assert dout_valid for exactly the following cycle (latency 1 cycle from final beat).
REQ-016 SHALL hold slot, staging, dout, and state unchanged on cycles with din_valid=0; gaps of any length are legal mid-frame.
REQ-017 SHALL, on a LOCKED beat with fsync=1 at slot 0, clear the miss count.
REQ-018 SHALL, on a LOCKED beat with fsync=1 at slot 1..7, pulse sync_err, discard the partial frame (no dout_valid), clear staging, treat the beat as channel 0 (staging[0]=din, slot=1), and clear the miss count.
REQ-019 SHALL, on a LOCKED beat with fsync=0 at slot 0, pulse sync_err and increment the miss count; if the new count is below MISS_LIMIT, accept the beat as channel 0.
REQ-020 SHALL, when the miss count reaches MISS_LIMIT, discard that beat, set slot=0, clear staging, and return to HUNT (locked=0 next cycle); dout keeps its last value.
REQ-021 SHALL keep dout unchanged except on REQ-015 loads; partial frames never reach dout.
REQ-022 SHALL register all outputs; no combinational path from inputs to outputs.

Reset
REQ-023 SHALL, while rst=1, immediately force state=HUNT, slot=0, staging=0, miss count=0, dout=8'h00, dout_valid=0, locked=0, sync_err=0.
REQ-024 SHALL discard any partial frame when rst asserts mid-frame and require a new fsync after release.

Verification
REQ-025 SHALL cover aligned frame: fsync on beat 0, bits 1,0,1,1,0,0,1,0 contiguous -> dout=8'h4D, dout_valid one cycle after beat 7, locked=1, sync_err never high.
REQ-026 SHALL cover gapped frame: same data as REQ-025 with din_valid low for 3 cycles after beats 2 and 5 -> dout=8'h4D, single dout_valid pulse, slot frozen during gaps.
REQ-027 SHALL cover early fsync: fsync at slot 4 of second frame -> sync_err pulse that cycle+1, no dout_valid for that frame, slot=1 next cycle, next 7 beats complete a frame.
REQ-028 SHALL cover lock loss with MISS_LIMIT=2: two consecutive frames without fsync -> first miss frame delivered with sync_err, second miss -> locked=0, 8 further fsync-free beats produce no dout_valid.
REQ-029 SHALL cover reset mid-frame: rst pulse at slot 5 -> dout=8'h00, slot=0, locked=0; frame after next fsync delivered correctly.
REQ-030 SHALL cover HUNT filtering: 20 beats with fsync=0 after reset -> locked stays 0, slot stays 0, no dout_valid.
